// File: rtl/cva6_region_cfg_checker.sv
// Physical-memory region table self-check: walks the non-idempotent, execute and
// cached rule tables one entry per cycle, then cross-checks cached vs non-idempotent rules.

package config_pkg;
    localparam int unsigned NrMaxRules = 16;

    typedef struct packed {
        int unsigned                  PLEN;
        int unsigned                  NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
        int unsigned                  NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
        int unsigned                  NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cva6_region_cfg_checker #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
    parameter int unsigned           MaxRules = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_class_o,
    output logic [3:0] err_idx_o,
    output logic [3:0] err_idx2_o,
    output logic [1:0] err_code_o,
    output logic [2:0] dbg_state_o
);

    // Handshake: start_i is a one-cycle request honoured only when busy_o=0; the verdict
    // (done_o with err_*) is valid from the cycle busy_o falls and holds until the next start.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHK_NI = 3'd1,
        CHK_EX = 3'd2,
        CHK_CA = 3'd3,
        CHK_XC = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] ClassNi = 2'd0;
    localparam logic [1:0] ClassEx = 2'd1;
    localparam logic [1:0] ClassCa = 2'd2;
    localparam logic [1:0] ClassXc = 2'd3;

    localparam logic [1:0] CodeMisaligned = 2'd0;
    localparam logic [1:0] CodePlen       = 2'd1;
    localparam logic [1:0] CodeOverlap    = 2'd2;

    localparam int unsigned NrNi = CVA6Cfg.NrNonIdempotentRules;
    localparam int unsigned NrEx = CVA6Cfg.NrExecuteRegionRules;
    localparam int unsigned NrCa = CVA6Cfg.NrCachedRegionRules;

    if (MaxRules > config_pkg::NrMaxRules || NrNi > MaxRules || NrEx > MaxRules ||
        NrCa > MaxRules) begin : g_bad_cfg
        $error("cva6_region_cfg_checker: rule count exceeds MaxRules");
    end

    localparam logic [3:0] NiLast = 4'((NrNi == 0) ? 0 : NrNi - 1);
    localparam logic [3:0] ExLast = 4'((NrEx == 0) ? 0 : NrEx - 1);
    localparam logic [3:0] CaLast = 4'((NrCa == 0) ? 0 : NrCa - 1);

    // Table order is fixed; empty tables are skipped at elaboration time.
    localparam bit     RunXc      = (NrNi > 0) && (NrCa > 0);
    localparam state_t AfterCa    = RunXc ? CHK_XC : DONE;
    localparam state_t AfterEx    = (NrCa > 0) ? CHK_CA : DONE;
    localparam state_t AfterNi    = (NrEx > 0) ? CHK_EX : AfterEx;
    localparam state_t AfterStart = (NrNi > 0) ? CHK_NI : AfterNi;

    localparam logic [64:0] PlenLimit = 65'd1 << CVA6Cfg.PLEN;

    // Returns {fail, code}; alignment is checked before the PLEN bound.
    function automatic logic [2:0] check_rule(input logic [63:0] base, input logic [63:0] len);
        logic [64:0] top;
        top = {1'b0, base} + {1'b0, len};
        if (len == '0) return 3'b000;
        if (base[1:0] != 2'b00 || len[1:0] != 2'b00) return {1'b1, CodeMisaligned};
        if (top > PlenLimit) return {1'b1, CodePlen};
        return 3'b000;
    endfunction

    function automatic logic overlaps(input logic [63:0] a_base, input logic [63:0] a_len,
                                      input logic [63:0] b_base, input logic [63:0] b_len);
        logic [64:0] a_top, b_top;
        a_top = {1'b0, a_base} + {1'b0, a_len};
        b_top = {1'b0, b_base} + {1'b0, b_len};
        return (a_len != '0) && (b_len != '0) &&
               ({1'b0, a_base} < b_top) && ({1'b0, b_base} < a_top);
    endfunction

    state_t     state_q;
    logic [3:0] idx_q;
    logic [3:0] jdx_q;

    logic [2:0] chk_res;
    logic [1:0] chk_class;
    logic       step_last;
    state_t     step_next;

    assign dbg_state_o = state_q;

    always_comb begin
        chk_res   = 3'b000;
        chk_class = ClassNi;
        step_last = 1'b0;
        step_next = DONE;
        case (state_q)
            CHK_NI: begin
                chk_res   = check_rule(CVA6Cfg.NonIdempotentAddrBase[idx_q],
                                       CVA6Cfg.NonIdempotentLength[idx_q]);
                chk_class = ClassNi;
                step_last = (idx_q == NiLast);
                step_next = AfterNi;
            end
            CHK_EX: begin
                chk_res   = check_rule(CVA6Cfg.ExecuteRegionAddrBase[idx_q],
                                       CVA6Cfg.ExecuteRegionLength[idx_q]);
                chk_class = ClassEx;
                step_last = (idx_q == ExLast);
                step_next = AfterEx;
            end
            CHK_CA: begin
                chk_res   = check_rule(CVA6Cfg.CachedRegionAddrBase[idx_q],
                                       CVA6Cfg.CachedRegionLength[idx_q]);
                chk_class = ClassCa;
                step_last = (idx_q == CaLast);
                step_next = AfterCa;
            end
            CHK_XC: begin
                // idx_q walks the cached table (outer), jdx_q the non-idempotent table (inner).
                chk_res   = {overlaps(CVA6Cfg.CachedRegionAddrBase[idx_q],
                                      CVA6Cfg.CachedRegionLength[idx_q],
                                      CVA6Cfg.NonIdempotentAddrBase[jdx_q],
                                      CVA6Cfg.NonIdempotentLength[jdx_q]), CodeOverlap};
                chk_class = ClassXc;
                step_last = (jdx_q == NiLast) && (idx_q == CaLast);
                step_next = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            jdx_q       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_class_o <= '0;
            err_idx_o   <= '0;
            err_idx2_o  <= '0;
            err_code_o  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q     <= AfterStart;
                        idx_q       <= '0;
                        jdx_q       <= '0;
                        busy_o      <= (AfterStart != DONE);
                        done_o      <= (AfterStart == DONE);
                        err_o       <= 1'b0;
                        err_class_o <= '0;
                        err_idx_o   <= '0;
                        err_idx2_o  <= '0;
                        err_code_o  <= '0;
                    end
                end
                CHK_NI, CHK_EX, CHK_CA, CHK_XC: begin
                    if (chk_res[2]) begin
                        state_q     <= DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        err_o       <= 1'b1;
                        err_class_o <= chk_class;
                        err_idx_o   <= idx_q;
                        err_idx2_o  <= (state_q == CHK_XC) ? jdx_q : 4'd0;
                        err_code_o  <= chk_res[1:0];
                    end else if (step_last) begin
                        state_q <= step_next;
                        idx_q   <= '0;
                        jdx_q   <= '0;
                        if (step_next == DONE) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end else if (state_q == CHK_XC) begin
                        if (jdx_q == NiLast) begin
                            jdx_q <= '0;
                            idx_q <= idx_q + 4'd1;
                        end else begin
                            jdx_q <= jdx_q + 4'd1;
                        end
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_region_cfg_checker.sv
// Bench for cva6_region_cfg_checker: several instances, each elaborated with its own
// region configuration, share clock and reset; verdicts flow through an expected queue.

module tb_cva6_region_cfg_checker;

    localparam int N = 9;
    localparam int W = 29;

    logic       clk = 1'b0;
    logic       rst;
    logic       start    [N];
    logic       busy     [N];
    logic       done     [N];
    logic       err      [N];
    logic [1:0] err_class[N];
    logic [3:0] err_idx  [N];
    logic [3:0] err_idx2 [N];
    logic [1:0] err_code [N];
    logic [2:0] dbg_state[N];

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Configuration per instance index.
    function automatic config_pkg::cva6_cfg_t make_cfg(input int k);
        config_pkg::cva6_cfg_t c;
        c = config_pkg::cva6_cfg_empty;
        c.PLEN = 56;
        case (k)
            0, 1: begin
                c.NrNonIdempotentRules     = 1;
                c.NonIdempotentAddrBase[0] = 64'h0;
                c.NonIdempotentLength[0]   = 64'h1000;
                c.NrExecuteRegionRules     = 2;
                c.ExecuteRegionAddrBase[0] = 64'h1000;
                c.ExecuteRegionLength[0]   = 64'h2000;
                c.ExecuteRegionAddrBase[1] = (k == 1) ? 64'h8000_0002 : 64'h8000_0000;
                c.ExecuteRegionLength[1]   = 64'h4000_0000;
                c.NrCachedRegionRules      = 1;
                c.CachedRegionAddrBase[0]  = 64'h8000_0000;
                c.CachedRegionLength[0]    = 64'h4000_0000;
            end
            2: begin
                c.PLEN                    = 34;
                c.NrCachedRegionRules     = 1;
                c.CachedRegionAddrBase[0] = 64'h3_FFFF_F000;
                c.CachedRegionLength[0]   = 64'h2000;
            end
            3: begin
                c.NrNonIdempotentRules     = 3;
                c.NonIdempotentAddrBase[0] = 64'h0;
                c.NonIdempotentLength[0]   = 64'h1000;
                c.NonIdempotentAddrBase[1] = 64'h1000;
                c.NonIdempotentLength[1]   = 64'h1000;
                c.NonIdempotentAddrBase[2] = 64'h8000_0000;
                c.NonIdempotentLength[2]   = 64'h100;
                c.NrCachedRegionRules      = 1;
                c.CachedRegionAddrBase[0]  = 64'h8000_0000;
                c.CachedRegionLength[0]    = 64'h4000_0000;
            end
            5, 6: begin
                c.NrNonIdempotentRules = 16;
                for (int i = 0; i < 15; i++) begin
                    c.NonIdempotentAddrBase[i] = 64'(i) * 64'h1000;
                    c.NonIdempotentLength[i]   = 64'h1000;
                end
                c.NonIdempotentAddrBase[15] = (k == 5) ? 64'h8000_1000 : 64'h3;
                c.NonIdempotentLength[15]   = (k == 5) ? 64'h0 : 64'h100;
                if (k == 5) begin
                    c.NrCachedRegionRules     = 1;
                    c.CachedRegionAddrBase[0] = 64'h8000_0000;
                    c.CachedRegionLength[0]   = 64'h4000_0000;
                end
            end
            7: begin
                c.PLEN                     = 34;
                c.NrNonIdempotentRules     = 1;
                c.NonIdempotentAddrBase[0] = 64'h0;
                c.NonIdempotentLength[0]   = 64'h1000;
                c.NrExecuteRegionRules     = 1;
                c.ExecuteRegionAddrBase[0] = 64'h3_FFFF_F000;
                c.ExecuteRegionLength[0]   = 64'h1000;
                c.NrCachedRegionRules      = 1;
                c.CachedRegionAddrBase[0]  = 64'h1000;
                c.CachedRegionLength[0]    = 64'h1000;
            end
            8: begin
                c.PLEN                     = 34;
                c.NrExecuteRegionRules     = 1;
                c.ExecuteRegionAddrBase[0] = 64'h3_FFFF_F001;
                c.ExecuteRegionLength[0]   = 64'h2000;
            end
            default: ;
        endcase
        return c;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        cva6_region_cfg_checker #(
            .CVA6Cfg (make_cfg(g)),
            .MaxRules(16)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .start_i    (start[g]),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .err_o      (err[g]),
            .err_class_o(err_class[g]),
            .err_idx_o  (err_idx[g]),
            .err_idx2_o (err_idx2[g]),
            .err_code_o (err_code[g]),
            .dbg_state_o(dbg_state[g])
        );
    end

    // Verdict record: {latency, busy cycles, err, class, idx, idx2, code}.
    function automatic logic [W-1:0] pack(input int lat, input int bsy, input int e, input int cls,
                                          input int idx, input int idx2, input int code);
        return {8'(lat), 8'(bsy), 1'(e), 2'(cls), 4'(idx), 4'(idx2), 2'(code)};
    endfunction

    function automatic logic [17:0] status(input int k);
        return {dbg_state[k], busy[k], done[k], err[k], err_class[k], err_idx[k], err_idx2[k],
                err_code[k]};
    endfunction

    // Pulses start on instance k, optionally re-pulses it at cycle 'poke' of the run,
    // and measures cycles until done (bounded at 200).
    task automatic do_run(input int k, input int poke, output logic [W-1:0] obs);
        int lat;
        int bsy;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        lat = 1;
        bsy = 0;
        while (!done[k] && lat < 200) begin
            if (busy[k]) bsy++;
            start[k] = (lat == poke);
            @(negedge clk);
            lat++;
        end
        start[k] = 1'b0;
        if (busy[k]) bsy++;
        obs = {8'(lat), 8'(bsy), err[k], err_class[k], err_idx[k], err_idx2[k], err_code[k]};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) start[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            total++;
            if (status(k) !== 18'h0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got %h want %h", k, status(k), 18'h0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(6, 5, 0, 0, 0, 0, 0));
        do_run(0, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL clean_run: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_misaligned();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(4, 3, 1, 1, 1, 0, 0));
        do_run(1, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL misaligned_run: got %h want %h", obs, exp);
        end
        repeat (5) @(negedge clk);
        total++;
        if (status(1) !== {3'd5, 1'b0, 1'b1, 1'b1, 2'd1, 4'd1, 4'd0, 2'd0}) begin
            bad++;
            $display("FAIL misaligned_hold: got %h want %h", status(1),
                     {3'd5, 1'b0, 1'b1, 1'b1, 2'd1, 4'd1, 4'd0, 2'd0});
        end
        exp_q.push_back(pack(4, 3, 1, 1, 1, 0, 0));
        do_run(1, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL misaligned_restart: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_plen();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(2, 1, 1, 2, 0, 0, 1));
        do_run(2, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL plen_overflow: got %h want %h", obs, exp);
        end
        exp_q.push_back(pack(5, 4, 0, 0, 0, 0, 0));
        do_run(7, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL plen_exact_and_adjacent: got %h want %h", obs, exp);
        end
        exp_q.push_back(pack(2, 1, 1, 1, 0, 0, 0));
        do_run(8, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL align_before_plen: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_overlap();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(8, 7, 1, 3, 0, 2, 2));
        do_run(3, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL overlap_run: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_empty();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0));
        do_run(4, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL empty_tables: got %h want %h", obs, exp);
        end
        exp_q.push_back(pack(34, 33, 0, 0, 0, 0, 0));
        do_run(5, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL zero_len_in_cached: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_full_table();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(17, 16, 1, 0, 15, 0, 0));
        do_run(6, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL full_table_last_idx: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_busy_start();
        logic [W-1:0] obs, exp;
        exp_q.push_back(pack(6, 5, 0, 0, 0, 0, 0));
        do_run(0, 2, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL start_while_busy: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] obs, exp;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (status(0) !== 18'h0) begin
            bad++;
            $display("FAIL midrun_reset: got %h want %h", status(0), 18'h0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (status(0) !== 18'h0) begin
            bad++;
            $display("FAIL midrun_stays_idle: got %h want %h", status(0), 18'h0);
        end
        exp_q.push_back(pack(6, 5, 0, 0, 0, 0, 0));
        do_run(0, 0, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL rerun_after_reset: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) start[k] = 1'b0;
        test_reset();
        test_clean();
        test_misaligned();
        test_plen();
        test_overlap();
        test_empty();
        test_full_table();
        test_busy_start();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
